// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential right shifter.
// Holds FSM states, fill-mode encodings and the legal STEP set.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic FILL_LOGICAL = 1'b0;
   localparam logic FILL_ARITH   = 1'b1;

   localparam int STEP_MAX = 4;

   // Bit s set means STEP = s is supported (1, 2, 4).
   localparam logic [STEP_MAX:0] STEP_SET = 5'b10110;

   function automatic bit step_legal(int s);
      step_legal = 1'b0;
      if (s >= 1 && s <= STEP_MAX) begin
         step_legal = STEP_SET[s];
      end
   endfunction

endpackage

// File: rtl/seq_shift_right_32bit_if.sv
// Request/response bundle between the EX stage and the shifter.
// master issues Start with operands; slave returns Busy/Done/Out.
interface seq_shift_right_32bit_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);

   logic               Start;
   logic [WIDTH-1:0]   In;
   logic [SHAMT_W-1:0] Shamt;
   logic               Arith;
   logic               Busy;
   logic               Done;
   logic [WIDTH-1:0]   Out;

   modport master (
      output Start, In, Shamt, Arith,
      input  Busy, Done, Out
   );

   modport slave (
      input  Start, In, Shamt, Arith,
      output Busy, Done, Out
   );

endinterface

// File: rtl/shift_right_step.sv
// One combinational right-shift step of 0..STEP_MAX positions.
// Vacated upper bits are filled with the supplied fill bit.
module shift_right_step #(
   parameter int WIDTH = 32,
   parameter int KW    = 3
) (
   input  logic [WIDTH-1:0] d,
   input  logic [KW-1:0]    k,
   input  logic             fill,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] mask;

   assign mask = ~({WIDTH{1'b1}} >> k);
   assign q    = (d >> k) | (fill ? mask : '0);

endmodule

// File: rtl/seq_shift_right_32bit.sv
// Multi-cycle logical/arithmetic right shifter for SRL/SRA/SRLV/SRAV.
// Shifts up to STEP bits per cycle; Busy stalls the pipe until Done.
module seq_shift_right_32bit
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic               Clk,
   input  logic               Reset,
   seq_shift_right_32bit_if.slave bus
);

   localparam int KW = $clog2(STEP_MAX + 1);

   generate
      if (!step_legal(STEP)) begin : g_bad_step
         $error("seq_shift_right_32bit: STEP must be 1, 2 or 4");
      end
   endgenerate

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   work_q;
   logic [WIDTH-1:0]   work_step;
   logic [SHAMT_W-1:0] rem_q;
   logic               arith_q;
   logic               sign_q;
   logic               load;
   logic               adv;
   logic [KW-1:0]      k;
   logic               fill;

   // k = min(STEP, rem); the narrow slice is safe since rem < STEP there
   assign k = (rem_q < SHAMT_W'(STEP)) ? rem_q[KW-1:0] : KW'(STEP);

   // Fill comes from the sign captured at Start, not the shifting value
   assign fill = (arith_q == FILL_ARITH) && sign_q;

   shift_right_step #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_step (
      .d    (work_q),
      .k    (k),
      .fill (fill),
      .q    (work_step)
   );

   // State register
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath controls; DONE accepts Start like IDLE
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      adv     = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.Start) begin
               load    = 1'b1;
               state_d = (bus.Shamt == '0) ? DONE : SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            adv = 1'b1;
            if (rem_q == SHAMT_W'(k)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Working, remaining-count and mode registers
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         work_q  <= '0;
         rem_q   <= '0;
         arith_q <= FILL_LOGICAL;
         sign_q  <= 1'b0;
      end else if (load) begin
         work_q  <= bus.In;
         rem_q   <= bus.Shamt;
         arith_q <= bus.Arith;
         sign_q  <= bus.In[WIDTH-1];
      end else if (adv) begin
         work_q  <= work_step;
         rem_q   <= rem_q - SHAMT_W'(k);
      end
   end

   assign bus.Busy = (state_q == SHIFT);
   assign bus.Done = (state_q == DONE);
   assign bus.Out  = work_q;

endmodule

// File: tb/tb_seq_shift_right_32bit.sv
// Scoreboard bench for seq_shift_right_32bit at STEP = 1, 2, 4.
// Stimulus pushes expected results; a monitor checks each Done.
module tb_seq_shift_right_32bit;

   typedef struct packed {
      logic [31:0] out;
      int          busy;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start [3];
   logic [31:0] in_v  [3];
   logic [4:0]  shamt [3];
   logic        arith [3];
   logic        busy  [3];
   logic        done  [3];
   logic [31:0] out_v [3];

   exp_t        expq  [3][$];
   int          bcnt  [3];
   int          lat   [3];
   bit          pend  [3];

   int          errors;
   int          checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_lane
         localparam int LSTEP = (g == 0) ? 1 : (g == 1) ? 2 : 4;

         seq_shift_right_32bit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

         assign bus.Start = start[g];
         assign bus.In    = in_v[g];
         assign bus.Shamt = shamt[g];
         assign bus.Arith = arith[g];
         assign busy[g]   = bus.Busy;
         assign done[g]   = bus.Done;
         assign out_v[g]  = bus.Out;

         seq_shift_right_32bit #(
            .WIDTH   (32),
            .SHAMT_W (5),
            .STEP    (LSTEP)
         ) dut (
            .Clk   (clk),
            .Reset (rst_n),
            .bus   (bus)
         );
      end
   endgenerate

   task automatic chk(string name, int l, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s lane%0d: got %h want %h", name, l, got, want);
      end
   endtask

   // Monitor: tracks acceptance, busy cycles and latency per lane
   always @(negedge clk) begin
      for (int l = 0; l < 3; l++) begin
         if (!rst_n) begin
            pend[l] = 1'b0;
            bcnt[l] = 0;
            lat[l]  = 0;
         end else begin
            if (pend[l]) lat[l]++;
            if (busy[l]) bcnt[l]++;
            if (done[l]) begin
               chk("busy_with_done", l, 32'(busy[l]), 32'd0);
               if (expq[l].size() == 0) begin
                  chk("unexpected_done", l, 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = expq[l].pop_front();
                  chk("out", l, out_v[l], e.out);
                  chk("busy_cycles", l, 32'(bcnt[l]), 32'(e.busy));
                  chk("latency", l, 32'(lat[l]), 32'(e.busy + 1));
               end
               pend[l] = 1'b0;
               bcnt[l] = 0;
            end
            if (start[l] && !busy[l]) begin
               pend[l] = 1'b1;
               lat[l]  = 0;
            end
         end
      end
   end

   task automatic setup(int l, logic [31:0] a, logic [4:0] s, logic ar);
      start[l] = 1'b1;
      in_v[l]  = a;
      shamt[l] = s;
      arith[l] = ar;
   endtask

   task automatic issue(int l, logic [31:0] a, logic [4:0] s, logic ar,
                        logic [31:0] eo, int eb);
      exp_t e;
      setup(l, a, s, ar);
      e.out  = eo;
      e.busy = eb;
      expq[l].push_back(e);
   endtask

   task automatic pulse();
      @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++) start[l] = 1'b0;
   endtask

   task automatic wait_done(int l);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done[l]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", l, 32'd0, 32'd1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      for (int l = 0; l < 3; l++) begin
         start[l] = 1'b0;
         in_v[l]  = '0;
         shamt[l] = '0;
         arith[l] = 1'b0;
      end

      // Reset state on every lane
      repeat (2) @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++) begin
         chk("rst_busy", l, 32'(busy[l]), 32'd0);
         chk("rst_done", l, 32'(done[l]), 32'd0);
         chk("rst_out", l, out_v[l], 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Logical shift
      issue(0, 32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000, 4);
      pulse();
      wait_done(0);
      @(posedge clk);
      #1;

      // Arithmetic worst case across STEP values
      issue(0, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 31);
      issue(1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 16);
      issue(2, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 8);
      pulse();
      wait_done(2);
      wait_done(1);
      wait_done(0);
      @(posedge clk);
      #1;

      // Zero shift
      issue(0, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 0);
      pulse();
      wait_done(0);
      @(posedge clk);
      #1;

      // Start mid-SHIFT is dropped, then back-to-back from DONE
      issue(0, 32'hF000_0000, 5'd3, 1'b1, 32'hFE00_0000, 3);
      pulse();
      @(posedge clk);
      #1;
      setup(0, 32'hFFFF_FFFF, 5'd5, 1'b1);
      pulse();
      wait_done(0);
      issue(0, 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 8);
      pulse();
      wait_done(0);
      @(posedge clk);
      #1;

      // Reset during the 3rd SHIFT cycle aborts without Done
      setup(0, 32'hAAAA_5555, 5'd10, 1'b0);
      pulse();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", 0, 32'(busy[0]), 32'd0);
      chk("abort_done", 0, 32'(done[0]), 32'd0);
      chk("abort_out", 0, out_v[0], 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_busy", 0, 32'(busy[0]), 32'd0);
      chk("idle_done", 0, 32'(done[0]), 32'd0);

      // Normal operation after abort, partial final steps
      issue(0, 32'h0000_F000, 5'd12, 1'b1, 32'h0000_000F, 12);
      issue(1, 32'h8000_0000, 5'd3, 1'b0, 32'h1000_0000, 2);
      issue(2, 32'h8000_0000, 5'd9, 1'b1, 32'hFFC0_0000, 3);
      pulse();
      wait_done(1);
      wait_done(2);
      wait_done(0);

      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++) begin
         chk("queue_empty", l, 32'(expq[l].size()), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
